nbit_rr_stream_mux: RTL

Parametrised N-channel, registered stream multiplexer with valid/ready handshakes on every input and on the output. Generalises the two-input combinational bus mux to NUM_CH channels, adds a one-entry output register, and selects by either an external select or round-robin arbitration. Sits between multiple producer blocks and a single shared consumer (bus, FIFO or datapath stage).

---
 rtl/nbit_mux_pkg.sv | 13 +
 rtl/nbit_rr_arbiter.sv | 32 +++
 rtl/nbit_rr_stream_mux.sv | 102 ++++++++++
 3 files changed

// File: rtl/nbit_mux_pkg.sv
// Shared constants and helpers for the N-channel registered stream mux.
// Pure declarations: no logic, no latency, no flow control.
package nbit_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Select/index width: max(1, clog2(n)), so a 2-channel mux still has a 1-bit index.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nbit_rr_arbiter.sv
// Round-robin grant search starting just after ptr; one-hot grant plus encoded index.
// Purely combinational (zero latency); enable=0 forces an empty grant.
module nbit_rr_arbiter import nbit_mux_pkg::*; #(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  idx
);

  always_comb begin : p_search
    int   c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    // Visit ptr+1, ptr+2, ... wrapping; the last granted channel is visited last.
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(ptr) + k) % NUM_CH;
      if (enable && !found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/nbit_rr_stream_mux.sv
// N-channel valid/ready stream mux into a one-entry output register (fixed select or round-robin).
// Latency one cycle; full throughput; out_ready=0 while full drops every in_ready.
module nbit_rr_stream_mux import nbit_mux_pkg::*; #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MODE       = 1,
  localparam int SEL_W      = sel_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [SEL_W-1:0]             sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0]      ch_q,    ch_d;
  logic [SEL_W-1:0]      ptr_q,   ptr_d;

  logic              load_en;
  logic              grant_en;
  logic              xfer_in;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;

  assign out_valid = (state_q == ST_FULL);
  assign load_en   = !out_valid || out_ready;
  // Gating with rst_n keeps in_ready low for the whole time reset is held.
  assign grant_en  = load_en && rst_n;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^sel;

      nbit_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req    (in_valid),
        .ptr    (ptr_q),
        .enable (grant_en),
        .grant  (grant),
        .idx    (grant_idx)
      );
    end else begin : g_fixed
      logic unused_ptr;
      assign unused_ptr = ^ptr_q;

      // Out-of-range select simply grants nothing.
      always_comb begin
        grant     = '0;
        grant_idx = sel;
        if (grant_en && (int'(sel) < NUM_CH)) begin
          grant[sel] = in_valid[sel];
        end
      end
    end
  endgenerate

  assign in_ready = grant;
  assign xfer_in  = |grant;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (xfer_in) begin
      state_d = ST_FULL;
      data_d  = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      ch_d    = grant_idx;
      ptr_d   = grant_idx;
    end else if (out_valid && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= SEL_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data = data_q;
  assign out_ch   = ch_q;

endmodule
